// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master/slave pair.
// Holds the FSM state encodings, default frame field widths and the start-bit level.
// Frame: START_BIT, slave ID, address, then data for writes; each field is sent LSB first.
package bus_pkg;

  localparam int SLAVE_ID_W = 3;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 8;

  // A slave read response also opens with this level.
  localparam logic START_BIT = 1'b0;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ARB_WAIT  = 4'd1,
    START     = 4'd2,
    SEND_ID   = 4'd3,
    SEND_ADDR = 4'd4,
    SEND_DATA = 4'd5,
    RX_WAIT   = 4'd6,
    RX_DATA   = 4'd7,
    WAIT_FREE = 4'd8,
    DONE      = 4'd9
  } state_t;

endpackage

// File: rtl/serial_shifter.sv
// Parallel-load / serial-out and serial-in / parallel-out shift register with a bit counter.
// Ports: load (takes load_dat, clears cnt), shift (moves right, sin enters at MSB, cnt+1),
//        sout (current LSB), head (top RX_W bits, i.e. the bits shifted in most recently), cnt.
module serial_shifter #(
  parameter int W    = 15,
  parameter int CW   = 5,
  parameter int RX_W = 7
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic [W-1:0]    load_dat,
  input  logic            shift,
  input  logic            sin,
  output logic            sout,
  output logic [RX_W-1:0] head,
  output logic [CW-1:0]   cnt
);

  logic [W-1:0] sreg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_dat;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= {sin, sreg[W-1:1]};
      cnt  <= cnt + 1'b1;
    end
  end

  assign sout = sreg[0];
  assign head = sreg[W-1 -: RX_W];

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: takes a parallel request, wins the bus, serialises
// start/ID/address/(data), and for reads collects the slave's serial reply.
// Ports: req/req_* (request, sampled in IDLE), arbiter_req/arbiter_cmd_in (arbitration),
//        slave_busy, bus_util, rd_wrt, data_bus_serial (bus side), rd_data/done/timeout_err/busy/state.
import bus_pkg::*;

module bus_master_port #(
  parameter int ADDRESS_WIDTH  = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int SLAVE_ID_WIDTH = SLAVE_ID_W,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req,
  input  logic                      req_rd_wrt,
  input  logic [SLAVE_ID_WIDTH-1:0] req_slave_id,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]     req_data,
  output logic                      arbiter_req,
  input  logic                      arbiter_cmd_in,
  input  logic                      slave_busy,
  output logic                      bus_util,
  output logic                      rd_wrt,
  inout  wire                       data_bus_serial,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      done,
  output logic                      timeout_err,
  output logic                      busy,
  output logic [3:0]                state
);

  localparam int MAXW = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW) + 1;

  state_t cur, nxt;

  logic                      dir_q;
  logic [SLAVE_ID_WIDTH-1:0] id_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [7:0]                tcnt;
  logic                      err_q;

  logic                  sh_load, sh_shift, sh_sout;
  logic [MAXW-1:0]       sh_dat;
  logic [DATA_WIDTH-2:0] sh_head;
  logic [CW-1:0]         cnt;
  logic                  drive_en, drive_bit, bus_in, active;

  assign bus_in = data_bus_serial;

  serial_shifter #(.W(MAXW), .CW(CW), .RX_W(DATA_WIDTH-1)) u_shifter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (sh_load),
    .load_dat (sh_dat),
    .shift    (sh_shift),
    .sin      (bus_in),
    .sout     (sh_sout),
    .head     (sh_head),
    .cnt      (cnt)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur <= IDLE;
    else       cur <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:      if (req) nxt = ARB_WAIT;
      ARB_WAIT:  if (arbiter_cmd_in) nxt = START;
      START:     nxt = SEND_ID;
      SEND_ID:   if (cnt == CW'(SLAVE_ID_WIDTH-1)) nxt = SEND_ADDR;
      SEND_ADDR: if (cnt == CW'(ADDRESS_WIDTH-1)) nxt = dir_q ? SEND_DATA : RX_WAIT;
      SEND_DATA: if (cnt == CW'(DATA_WIDTH-1)) nxt = WAIT_FREE;
      WAIT_FREE: if (!slave_busy) nxt = DONE;
      RX_WAIT: begin
        if (bus_in == START_BIT)            nxt = RX_DATA;
        else if (tcnt == 8'(TIMEOUT-1))     nxt = DONE;
      end
      RX_DATA:   if (cnt == CW'(DATA_WIDTH-1)) nxt = DONE;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Outputs and shifter control
  always_comb begin
    active = (cur != IDLE) && (cur != ARB_WAIT) && (cur != DONE);
    arbiter_req = (cur == ARB_WAIT);
    busy        = (cur != IDLE) && (cur != DONE);
    done        = (cur == DONE);
    timeout_err = (cur == DONE) && err_q;
    bus_util    = !active;
    rd_wrt      = active && dir_q;
    drive_en    = (cur == START) || (cur == SEND_ID) || (cur == SEND_ADDR) || (cur == SEND_DATA);
    drive_bit   = (cur == START) ? START_BIT : sh_sout;
    // Every state entry reloads the shifter, which also clears the bit counter.
    sh_load = (nxt != cur);
    sh_dat  = '0;
    case (nxt)
      SEND_ID:   sh_dat = MAXW'(id_q);
      SEND_ADDR: sh_dat = MAXW'(addr_q);
      SEND_DATA: sh_dat = MAXW'(data_q);
      default:   sh_dat = '0;
    endcase
    sh_shift = !sh_load && ((cur == SEND_ID) || (cur == SEND_ADDR) ||
                            (cur == SEND_DATA) || (cur == RX_DATA));
  end

  assign data_bus_serial = drive_en ? drive_bit : 1'bz;
  assign state = cur;

  // Request buffers, timeout counter, read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dir_q   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      tcnt    <= 8'd0;
      err_q   <= 1'b0;
      rd_data <= '0;
    end else begin
      if (cur == IDLE && req) begin
        dir_q  <= req_rd_wrt;
        id_q   <= req_slave_id;
        addr_q <= req_addr;
        data_q <= req_data;
      end
      // Only RX_WAIT counts; it is always entered with tcnt already zero.
      tcnt  <= (cur == RX_WAIT) ? tcnt + 8'd1 : 8'd0;
      err_q <= (cur == RX_WAIT) && (nxt == DONE);
      // The last bit is taken straight off the bus so rd_data is valid while done is high.
      if (cur == RX_DATA && nxt == DONE) rd_data <= {bus_in, sh_head};
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed transactions push expected results into a queue,
// a negedge monitor captures the frame and pops/compares on every done pulse.
module tb_bus_master_port;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, req_rd_wrt;
  logic [2:0]  req_slave_id;
  logic [14:0] req_addr;
  logic [7:0]  req_data;
  logic        arbiter_req, arbiter_cmd_in, slave_busy;
  logic        bus_util, rd_wrt, done, timeout_err, busy;
  logic [7:0]  rd_data;
  logic [3:0]  state;
  logic        soe, sbit;
  wire         bus_line;

  assign bus_line = soe ? sbit : 1'bz;
  pullup (bus_line);

  bus_master_port dut (
    .clk(clk), .rstn(rstn), .req(req), .req_rd_wrt(req_rd_wrt),
    .req_slave_id(req_slave_id), .req_addr(req_addr), .req_data(req_data),
    .arbiter_req(arbiter_req), .arbiter_cmd_in(arbiter_cmd_in), .slave_busy(slave_busy),
    .bus_util(bus_util), .rd_wrt(rd_wrt), .data_bus_serial(bus_line),
    .rd_data(rd_data), .done(done), .timeout_err(timeout_err), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [26:0] frame;
    int          nbits;
    logic [7:0]  rdat;
    logic        terr;
    int          lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  logic        mon_active = 1'b0;
  int          g_cyc = 0;
  logic [26:0] cap;
  logic        util_bad, dir_seen;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_active = 1'b0;
    end else begin
      if (mon_active) begin
        int n;
        n = cyc - g_cyc;
        if (n >= 1 && n <= 27) cap[n-1] = bus_line;
        if (!done && bus_util) util_bad = 1'b1;
        if (n == 1) dir_seen = rd_wrt;
      end
      if (arbiter_req && arbiter_cmd_in) begin
        mon_active = 1'b1;
        g_cyc      = cyc;
        util_bad   = 1'b0;
        cap        = '1;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          logic [26:0] m;
          e = q.pop_front();
          m = (27'd1 << e.nbits) - 27'd1;
          chk("frame",       cap & m, e.frame & m);
          chk("done_latency", cyc - g_cyc, e.lat);
          chk("rd_data",     rd_data, e.rdat);
          chk("timeout_err", timeout_err, e.terr);
          chk("bus_util_low_in_txn", util_bad, 1'b0);
          chk("rd_wrt",      dir_seen, e.wr);
          chk("bus_util_at_done", bus_util, 1'b1);
          chk("busy_at_done", busy, 1'b0);
        end
        mon_active = 1'b0;
      end
    end
  end

  // One transaction: req at cycle r, grant at r+3 (= g), then per-cycle slave/busy/extra-req stimulus.
  task automatic txn(input logic wr, input logic [2:0] id, input logic [14:0] a, input logic [7:0] d,
                     input int rsp_dly, input logic [7:0] rsp, input int busy_cyc, input int xreq_off,
                     input logic [26:0] ef, input int enb, input logic [7:0] erd,
                     input logic eterr, input int elat);
    exp_t e;
    e.wr = wr; e.frame = ef; e.nbits = enb; e.rdat = erd; e.terr = eterr; e.lat = elat;
    q.push_back(e);
    req = 1'b1; req_rd_wrt = wr; req_slave_id = id; req_addr = a; req_data = d;
    tick();
    req = 1'b0;
    tick();
    tick();
    arbiter_cmd_in = 1'b1;
    for (int k = 1; k <= elat + 3; k++) begin
      tick();
      arbiter_cmd_in = 1'b0;
      if (k == 1) begin
        // Scramble the request inputs: the DUT must work from its buffered copy.
        req_rd_wrt = ~wr; req_slave_id = ~id; req_addr = ~a; req_data = ~d;
      end
      slave_busy = (busy_cyc > 0) && (k < 28 + busy_cyc);
      req = (k == xreq_off);
      if (rsp_dly >= 0) begin
        int s;
        s = 20 + rsp_dly;
        if (k == s) begin
          soe = 1'b1; sbit = 1'b0;
        end else if (k > s && k <= s + 8) begin
          soe = 1'b1; sbit = rsp[k-s-1];
        end else begin
          soe = 1'b0;
        end
      end
    end
    req = 1'b0;
    chk("idle_arbiter_req", arbiter_req, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_bus_util", bus_util, 1'b1);
    chk("bus_released", bus_line, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req = 1'b0; req_rd_wrt = 1'b0; req_slave_id = '0; req_addr = '0; req_data = '0;
    arbiter_cmd_in = 1'b0; slave_busy = 1'b0; soe = 1'b0; sbit = 1'b1;
    tick();
    chk("rst_state", state, 4'd0);
    chk("rst_arbiter_req", arbiter_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_bus_util", bus_util, 1'b1);
    chk("rst_rd_wrt", rd_wrt, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_bus_hiz", bus_line, 1'b1);
    tick();
    rstn = 1'b1;
    tick();

    // 1: write, extra req in the DONE cycle (k=29) must be ignored
    txn(1'b1, 3'd0, 15'h0005, 8'hA5, -1, 8'h00, 0, 29,
        {8'hA5, 15'h0005, 3'd0, 1'b0}, 27, 8'h00, 1'b0, 29);
    // 2: read, slave answers 4 cycles after release
    txn(1'b0, 3'd0, 15'h0010, 8'h00, 4, 8'h3C, 0, 0,
        {8'h00, 15'h0010, 3'd0, 1'b0}, 19, 8'h3C, 1'b0, 33);
    // 3: read timeout, rd_data keeps 3C
    txn(1'b0, 3'd1, 15'h2AAA, 8'h00, -1, 8'h00, 0, 0,
        {8'h00, 15'h2AAA, 3'd1, 1'b0}, 19, 8'h3C, 1'b1, 275);
    // 4: write with slave_busy held 10 cycles past the last data bit
    txn(1'b1, 3'd7, 15'h4001, 8'h81, -1, 8'h00, 10, 0,
        {8'h81, 15'h4001, 3'd7, 1'b0}, 27, 8'h3C, 1'b0, 39);

    // 5: reset in SEND_ADDR
    req = 1'b1; req_rd_wrt = 1'b1; req_slave_id = 3'd2; req_addr = 15'h1111; req_data = 8'h22;
    tick();
    req = 1'b0;
    tick();
    tick();
    arbiter_cmd_in = 1'b1;
    tick();
    arbiter_cmd_in = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    rstn = 1'b0;
    #1;
    chk("midrst_bus_hiz", bus_line, 1'b1);
    chk("midrst_bus_util", bus_util, 1'b1);
    chk("midrst_arbiter_req", arbiter_req, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_state", state, 4'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    txn(1'b0, 3'd6, 15'h0100, 8'h00, 0, 8'h5A, 0, 0,
        {8'h00, 15'h0100, 3'd6, 1'b0}, 19, 8'h5A, 1'b0, 29);

    // 6: grant pulse in IDLE, then a second req while busy
    arbiter_cmd_in = 1'b1;
    tick();
    arbiter_cmd_in = 1'b0;
    tick();
    chk("idle_grant_ignored_state", state, 4'd0);
    chk("idle_grant_ignored_util", bus_util, 1'b1);
    txn(1'b1, 3'd5, 15'h1234, 8'h3C, -1, 8'h00, 0, 10,
        {8'h3C, 15'h1234, 3'd5, 1'b0}, 27, 8'h5A, 1'b0, 29);

    tick();
    tick();
    chk("pending_expectations", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side serial bus interface; sits directly upstream of the memory slave on the shared serial bus.
- Accepts a parallel read/write request from a local module and requests the bus from the arbiter. Once granted, it serializes the slave ID, address and (for writes) data onto data_bus_serial.
- For reads, it captures the slave's serial response and returns it in parallel.
- Drives the bus_util and rd_wrt lines that slaves monitor.

Parameters:
- ADDRESS_WIDTH, 15, address bits sent per transaction
- DATA_WIDTH, 8, data bits per transfer
- SLAVE_ID_WIDTH, 3, slave-select bits
- TIMEOUT, 255, max cycles to wait for the slave read-response start bit

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- req  in  1  one-cycle request strobe from the local module
- req_rd_wrt  in  1  1=write, 0=read
- req_slave_id  in  SLAVE_ID_WIDTH  target slave
- req_addr  in  ADDRESS_WIDTH  target address
- req_data  in  DATA_WIDTH  write data
- arbiter_req  out  1  bus request to the arbiter
- arbiter_cmd_in  in  1  one-cycle grant pulse from the arbiter
- slave_busy  in  1  wired busy line from the slaves
- bus_util  out  1  active-low "bus in use"
- rd_wrt  out  1  transaction direction broadcast to the slaves
- data_bus_serial  inout  1  shared serial line; driven or hi-Z; idle reads 1 via pull-up
- rd_data  out  DATA_WIDTH  captured read data
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  one-cycle pulse; coincides with done on timeout
- busy  out  1  high from req acceptance until done
- state  out  4  current FSM state encoding, for debug

Behaviour:
- Reset is rstn, asynchronous, active-low; the clock is clk.
- Values held in reset:
  - state = IDLE
  - arbiter_req = 0, busy = 0, done = 0, timeout_err = 0
  - bus_util = 1, rd_wrt = 0
  - rd_data = 0
  - data_bus_serial hi-Z
- Request capture: req is sampled in IDLE only. All req_* fields are registered into internal buffers; req in any other state is ignored.
- Serial frame: all fields are sent LSB first, one bit per clk.
  - Start bit 0, then slave ID, then address, then data (writes only).
- FSM states: IDLE, ARB_WAIT, START, SEND_ID, SEND_ADDR, SEND_DATA, RX_WAIT, RX_DATA, WAIT_FREE, DONE.
- IDLE → ARB_WAIT on req. arbiter_req = 1 and busy = 1 from the next cycle.
- ARB_WAIT → START on arbiter_cmd_in = 1.
  - arbiter_req drops in the same cycle.
  - bus_util goes to 0 and rd_wrt takes the buffered direction.
  - Both are held until DONE.
- START: drive 0 for one cycle → SEND_ID.
- SEND_ID: SLAVE_ID_WIDTH cycles → SEND_ADDR.
- SEND_ADDR: ADDRESS_WIDTH cycles, then:
  - write → SEND_DATA
  - read → RX_WAIT; the bus is released (hi-Z) on entry.
- SEND_DATA: DATA_WIDTH cycles, then release the bus → WAIT_FREE.
- WAIT_FREE: stays while slave_busy = 1; → DONE when slave_busy = 0.
- RX_WAIT: sample the bus each cycle.
  - On 0 → RX_DATA.
  - After TIMEOUT cycles without a 0 → DONE, with timeout_err = 1 and rd_data unchanged.
- RX_DATA: shift in DATA_WIDTH bits, one per cycle starting the cycle after the start bit; then → DONE.
- DONE: done = 1 for one cycle, bus_util = 1, busy = 0 → IDLE.
  - rd_data is updated in the DONE cycle for successful reads.
- Counters:
  - A single bit counter, width ceil(log2(max(ADDRESS_WIDTH, DATA_WIDTH)))+1, is reset on each state entry.
  - A separate 8-bit timeout counter.
- Write latency: grant at cycle g → start bit on the bus at g+1 → last data bit at g+1+SLAVE_ID_WIDTH+ADDRESS_WIDTH+DATA_WIDTH → done at least 2 cycles later.
- A grant pulse in any state other than ARB_WAIT is ignored.
- A req arriving in the DONE cycle is ignored; the next req is accepted in IDLE.
- Reset mid-transfer: the bus is released immediately (hi-Z, bus_util = 1). No done pulse is issued, and the partial frame is abandoned.
- slave_busy is ignored outside WAIT_FREE.

Decomposition:
- Shared package bus_pkg holds:
  - state encodings
  - frame field widths
  - the START_BIT = 1'b0 constant, shared with the slave FSM
- One natural sub-module is serial_shifter: a parallel-load/serial-out and serial-in/parallel-out shift register with a bit counter, reusable by the slave.

Test Plan (defaults):
1. Write: req, rd_wrt=1, id=0, addr=15'h0005, data=8'hA5, grant 3 cycles later, slave_busy=0 → bus carries 0, 000, 101000000000000, 10100101; done at g+29; bus hi-Z afterwards.
2. Read: req, rd_wrt=0, id=0, addr=15'h0010; slave drives 0 then 8'h3C LSB-first 4 cycles after release → rd_data=8'h3C, done pulse, timeout_err=0, bus_util=1 after DONE.
3. Read timeout: no slave response → done and timeout_err both high exactly 255 cycles after the bus release; rd_data retains its previous value.
4. Write with slave_busy held high 10 cycles after the last data bit → done delayed by exactly 10 cycles; bus_util stays 0 throughout.
5. Reset asserted during SEND_ADDR → bus immediately hi-Z, bus_util=1, arbiter_req=0, busy=0, no done pulse; a new req afterwards completes normally.
6. Grant pulse in IDLE, and a second req while busy → both ignored; the first transaction completes unaltered and exactly one done pulse is issued.
